multi_cycle_control_fsm: RTL
============================

Name: multi_cycle_control_fsm

Overview:
Main control unit for the multi-stage RV32I core. It sequences the shared datapath (single memory port, single ALU, IR/OldPC/A/B/ALUOut/Data registers) through per-instruction state sequences and drives every mux select and write enable. It sits beside the datapath inside Multi_Stage_Top and replaces the combinational decoder used by the single-stage core.

Parameters:
MEM_WAIT_EN, 1, 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready; 0 = mem_ready ignored (treated as 1)

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous, active-high reset
opcode  input  7  IR[6:0]
funct3  input  3  IR[14:12]
funct7_5  input  1  IR[30]
branch_taken  input  1  datapath comparator result for current funct3
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC load enable
adr_src  output  1  0=PC, 1=Result
mem_write  output  1  memory write strobe
ir_write  output  1  IR and OldPC load enable
reg_write  output  1  register file write enable
result_src  output  2  00=ALUOut, 01=Data, 10=ALUResult
alu_src_a  output  2  00=PC, 01=OldPC, 10=A(rs1), 11=zero
alu_src_b  output  2  00=B(rs2), 01=Imm, 10=const 4
alu_control  output  4  ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001
instr_retired  output  1  one-cycle pulse on last cycle of each instruction
illegal  output  1  sticky illegal-opcode flag
state_dbg  output  4  current state encoding

Behaviour:
- Moore outputs decoded from state; exceptions: pc_write = pc_update | (branch & branch_taken); FETCH/MEMREAD/MEMWRITE enables gated by mem_ready.
- rst=1: state<=FETCH, illegal<=0; all enables (pc_write, mem_write, ir_write, reg_write) forced 0 while rst=1. First cycle after release is FETCH.
- FETCH: adr_src=0, src_a=00, src_b=10, ADD, result_src=10; ir_write=pc_update=mem_ready. Stay while !mem_ready, else DECODE.
- DECODE: src_a=01, src_b=01, ADD (ALUOut=branch/jal target). Next by opcode: 0000011/0100011 MEMADR; 0110011 EXECR; 0010011 EXECI; 1100011 BRANCH; 1101111 JAL; 1100111 JALR; 0110111 LUI; 0010111 AUIPC; other TRAP.
- MEMADR: src_a=10, src_b=01, ADD; lw->MEMREAD, sw->MEMWRITE.
- MEMREAD: result_src=00, adr_src=1; wait mem_ready -> MEMWB. MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: result_src=00, adr_src=1, mem_write=mem_ready; on mem_ready -> FETCH.
- EXECR: src_a=10, src_b=00, alu_op=FUNCT -> ALUWB. EXECI: src_a=10, src_b=01, alu_op=FUNCT -> ALUWB.
- LUI: src_a=11, src_b=01, ADD -> ALUWB. AUIPC: src_a=01, src_b=01, ADD -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BRANCH: src_a=10, src_b=00, SUB, result_src=00, branch=1 -> FETCH.
- JAL: src_a=01, src_b=10, ADD, result_src=00, pc_update=1 -> ALUWB (rd=OldPC+4).
- JALR: src_a=10, src_b=01, ADD -> JALR2. JALR2: src_a=01, src_b=10, ADD, result_src=00, pc_update=1 -> ALUWB.
- TRAP: illegal<=1, all enables 0, terminal until rst.
- Cycle counts (mem_ready=1): lw 5, sw 4, R/I/lui/auipc/jal 4, branch 3, jalr 5. Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
- instr_retired=1 in MEMWB, MEMWRITE (with mem_ready), ALUWB, BRANCH; never in TRAP.
- ALU decode: alu_op ADD/SUB forced; FUNCT: funct3 000 SUB if R-type & funct7_5 else ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRA if funct7_5 else SRL; 110 OR; 111 AND.
- rst mid-instruction (any state, incl. memory wait): next state FETCH, no write enable asserted in the reset cycle.

Decomposition:
- Package multi_cycle_pkg: state encoding (4-bit, FETCH=0), opcode constants, alu_control codes, result_src/alu_src_a/alu_src_b encodings, alu_op codes.
- Sub-module alu_decoder (alu_op, funct3, funct7_5, is_rtype -> alu_control), purely combinational.

Test Plan:
- rst 5 cycles then add x3,x1,x2 (0x002081B3), mem_ready=1 -> states FETCH,DECODE,EXECR,ALUWB; alu_control=0000 in EXECR; reg_write=1 only in ALUWB; instr_retired pulse at cycle 4.
- sub (funct7_5=1, opcode 0110011) -> alu_control=0001 in EXECR; srai (0010011, funct3=101, funct7_5=1) -> 1001; addi with IR[30]=1 -> 0000.
- lw with mem_ready=0 for 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; ir_write single pulse; reg_write with result_src=01 in MEMWB.
- beq taken=1 -> pc_write=1 in BRANCH, 3 cycles; taken=0 -> pc_write=0 there; sw -> mem_write single cycle coincident with mem_ready.
- jalr -> FETCH,DECODE,JALR,JALR2,ALUWB; pc_write=1 in JALR2 with result_src=00.
- opcode 0x7F -> TRAP, illegal=1 held, no enables; rst=1 asserted in MEMREAD of a lw -> FETCH next, illegal=0, mem_write/reg_write never high.

Source files
------------

// File: rtl/multi_cycle_pkg.sv
// Shared encodings for the multi-stage RV32I control unit: states, opcodes,
// ALU control codes and datapath mux selects.
package multi_cycle_pkg;

  localparam int unsigned STATE_W    = 4;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned OPCODE_W   = 7;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

endpackage

// File: rtl/multi_cycle_control_fsm_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields to an ALU control code.
module alu_decoder
  import multi_cycle_pkg::*;
(
  input  alu_op_t     alu_op,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        is_rtype,
  output alu_ctrl_t   alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// Control FSM for the multi-stage RV32I core: sequences the shared datapath
// and drives every mux select and write enable, decoded from current state.
module multi_cycle_control_fsm
  import multi_cycle_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       instr_retired,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t      state, state_nxt;
  result_src_t res_sel;
  src_a_t      src_a;
  src_b_t      src_b;
  alu_op_t     alu_op;
  alu_ctrl_t   alu_ctrl;
  logic        ready;
  logic        pc_update, branch;
  logic        mem_write_c, ir_write_c, reg_write_c, retired_c;

  assign ready = mem_ready | ~MEM_WAIT_EN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_TRAP) illegal <= 1'b1;
    end
  end

  // Next-state and Moore decode; memory-facing enables qualified by ready.
  always_comb begin
    state_nxt   = state;
    adr_src     = 1'b0;
    res_sel     = RES_ALUOUT;
    src_a       = SRCA_PC;
    src_b       = SRCB_RS2;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    retired_c   = 1'b0;
    case (state)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        res_sel    = RES_ALURESULT;
        ir_write_c = ready;
        pc_update  = ready;
        if (ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          OP_LUI:            state_nxt = S_LUI;
          OP_AUIPC:          state_nxt = S_AUIPC;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a     = SRCA_RS1;
        src_b     = SRCB_IMM;
        state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        res_sel     = RES_DATA;
        reg_write_c = 1'b1;
        retired_c   = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = ready;
        retired_c   = ready;
        if (ready) state_nxt = S_FETCH;
      end
      S_EXECR: begin
        src_a     = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        src_a     = SRCA_RS1;
        src_b     = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_LUI: begin
        src_a     = SRCA_ZERO;
        src_b     = SRCB_IMM;
        state_nxt = S_ALUWB;
      end
      S_AUIPC: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_IMM;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retired_c   = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_BRANCH: begin
        src_a     = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
        retired_c = 1'b1;
        state_nxt = S_FETCH;
      end
      // ALUOut already holds the jump target from DECODE/JALR; link is OldPC+4.
      S_JAL, S_JALR2: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_JALR: begin
        src_a     = SRCA_RS1;
        src_b     = SRCB_IMM;
        state_nxt = S_JALR2;
      end
      default: state_nxt = S_TRAP;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .is_rtype    (state == S_EXECR),
    .alu_control (alu_ctrl)
  );

  // Enables are suppressed while reset is held, whatever the state.
  assign pc_write      = ~rst & (pc_update | (branch & branch_taken));
  assign mem_write     = ~rst & mem_write_c;
  assign ir_write      = ~rst & ir_write_c;
  assign reg_write     = ~rst & reg_write_c;
  assign instr_retired = ~rst & retired_c;
  assign result_src    = res_sel;
  assign alu_src_a     = src_a;
  assign alu_src_b     = src_b;
  assign alu_control   = alu_ctrl;
  assign state_dbg     = state;

endmodule
